xvc_scheduler: RTL
==================

# xvc_scheduler

Round-robin virtual-channel scheduler that sits directly downstream of the tagged linked-list multi-VC FIFO. It watches the FIFO's per-VC non-empty flags and head data, selects one eligible VC per cycle, and issues the pop (`re`/`r_vc`). The popped flit goes into a single registered valid/ready output stage toward the switch crossbar. Optional per-VC credit counters gate eligibility so downstream VC buffers are never overrun.

## Interface
- `VCN`, 64: number of virtual channels; must match the upstream FIFO.
- `D`, 11: flit data width.
- `CREDITS`, 4: initial and maximum credits per VC; only used with credits compiled in.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `empty_n`  in  VCN  per-VC non-empty flags from the FIFO.
- `q`  in  VCN*D  per-VC head data from the FIFO; VC v occupies `q[v*D +: D]`.
- `re`  out  1  pop strobe to the FIFO.
- `r_vc`  out  clog2(VCN)  VC being popped; only meaningful while `re`=1.
- `o_valid`  out  1  output flit valid.
- `o_data`  out  D  output flit.
- `o_vc`  out  clog2(VCN)  VC of the output flit.
- `o_ready`  in  1  downstream accepts the flit.
- `crd_vld`  in  1  credit return strobe; credit build only.
- `crd_vc`  in  clog2(VCN)  VC receiving the returned credit; credit build only.

## Operation
- Eligibility: `elig[v] = empty_n[v] & (crd_cnt[v] != 0)`. Without credits, `elig = empty_n`.
- Slot free: `slot_free = ~o_valid | o_ready`.
- Grant:
  - `re = |elig & slot_free`.
  - `r_vc` is the first eligible VC found by scanning upward from `rr_ptr`, with wrap-around.
  - `re` and `r_vc` are combinational from the inputs and registered state; there is no other state machine.
- On grant:
  - `o_data <= q[r_vc*D +: D]`, `o_vc <= r_vc`, `o_valid <= 1`.
  - `rr_ptr <= r_vc + 1`, computed modulo VCN.
- Without a grant: if `o_ready & o_valid`, then `o_valid <= 0`. Otherwise the output holds.
- While `o_valid=1` and `o_ready=0`, `o_data` and `o_vc` are stable and `re=0`.
- Credits:
  - Grant to VC v decrements `crd_cnt[v]`.
  - `crd_vld` on VC c increments `crd_cnt[c]`.
  - A grant and a return on the same VC in the same cycle leave the count unchanged.
  - A return to a counter already at CREDITS saturates and is ignored.
- Reset values:
  - `o_valid=0`, `o_data=0`, `o_vc=0`.
  - `rr_ptr=0`.
  - `crd_cnt[*]=CREDITS`.
  - `re=0`, because `empty_n` is 0 out of reset.
- Reset asserted mid-operation discards the output flit immediately. Flits already popped from the FIFO are lost; that is acceptable only at system reset.

## Timing
- Pop-to-output latency is 1 cycle: grant in cycle t gives `o_valid` in t+1.
- The FIFO updates head, `q` and `empty_n` registered, so the same VC can be popped on consecutive cycles. Full throughput is 1 flit/cycle while `o_ready=1`.
- A VC that becomes non-empty in cycle t can be granted in cycle t.
- A returned credit makes its VC eligible in the cycle after `crd_vld`.
- Fairness: with all VCs continuously eligible, each VC is granted exactly once every VCN grants.

## Configuration
- `XVC_SCHED_CREDIT_EN` defined:
  - credit counters, `crd_vld` and `crd_vc` exist;
  - eligibility uses credits as described above.
- Undefined:
  - no counters;
  - `crd_vld` and `crd_vc` ports are still present but ignored;
  - eligibility is `empty_n` only.

## Structure
- Shared package `xswitch_pkg` holds:
  - `VA = $clog2(VCN)`;
  - `CW = $clog2(CREDITS+1)`;
  - typedef `vc_t` (`logic [VA-1:0]`).
- Sub-module `xrr_arbiter`: parameter N; inputs `req[N]`, `ptr`; outputs `gnt_any` and `gnt_idx`. It is purely combinational: a rotate, a priority encode, then an un-rotate. The pointer register stays in `xvc_scheduler`.

## Test plan
- Reset release with `empty_n=0` -> `re=0` and `o_valid=0` for 10 cycles; with credits, every `crd_cnt` reads 4.
- `empty_n` bits 3, 7 and 60 held high, `o_ready=1` -> grant sequence 3, 7, 60, 3, …; `o_vc` follows one cycle later with matching `q` data.
- Single VC 5 with 3 flits (0x001, 0x002, 0x003), `o_ready=1` -> 3 consecutive `re` with `r_vc=5`; `o_data` is 0x001, 0x002, 0x003 on consecutive cycles.
- `o_ready=0` for 4 cycles while `o_valid=1` -> `re=0` and `o_data` stable; after `o_ready` rises, the next grant follows in the same cycle.
- Credits, CREDITS=4, VC 2 always non-empty, no returns -> exactly 4 grants, then VC 2 is blocked. One `crd_vld` with `crd_vc=2` -> exactly one more grant.
- Credits: grant to VC 9 coinciding with a return to VC 9 -> `crd_cnt[9]` unchanged. A return to VC 9 while its count is 4 -> count stays 4.

Source files
------------

// File: rtl/xswitch_pkg.sv
// Shared definitions for the switch VC scheduler slice.
package xswitch_pkg;

  localparam int VCN_DEF     = 64;
  localparam int D_DEF       = 11;
  localparam int CREDITS_DEF = 4;

  localparam int VA = $clog2(VCN_DEF);
  localparam int CW = $clog2(CREDITS_DEF + 1);

  typedef logic [VA-1:0] vc_t;

endpackage

// File: rtl/xvc_scheduler_arb.sv
// Combinational round-robin arbiter: rotate requests so ptr sits at bit 0,
// pick the lowest set bit, then map the offset back to an absolute index.
module xrr_arbiter #(
  parameter int N = 64
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_any,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int W = $clog2(N);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;

  // rotate, priority-encode, un-rotate
  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < N; i++)
      rot[i] = req[(i + 32'(ptr)) % N];
    gnt_any = |req;
    off = '0;
    for (int unsigned i = N; i > 0; i--)
      if (rot[i-1]) off = W'(i - 1);
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    gnt_idx = sum[W-1:0];
  end

endmodule

// File: rtl/xvc_scheduler.sv
// Round-robin VC scheduler: pops one eligible VC per cycle from the upstream
// multi-VC FIFO into a single registered valid/ready output stage.
// Optional per-VC credit gating is compiled in with XVC_SCHED_CREDIT_EN.
module xvc_scheduler
  import xswitch_pkg::*;
#(
  parameter int VCN     = VCN_DEF,
  parameter int D       = D_DEF,
  parameter int CREDITS = CREDITS_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [VCN-1:0]          empty_n,
  input  logic [VCN*D-1:0]        q,
  output logic                    re,
  output logic [$clog2(VCN)-1:0]  r_vc,
  output logic                    o_valid,
  output logic [D-1:0]            o_data,
  output logic [$clog2(VCN)-1:0]  o_vc,
  input  logic                    o_ready,
  input  logic                    crd_vld,
  input  logic [$clog2(VCN)-1:0]  crd_vc
);

  localparam int LA = $clog2(VCN);

  logic [VCN-1:0] elig;
  logic [LA-1:0]  rr_ptr;
  logic           gnt_any;
  logic [LA-1:0]  gnt_idx;
  logic           slot_free;

`ifdef XVC_SCHED_CREDIT_EN
  localparam int CL = $clog2(CREDITS + 1);

  logic [CL-1:0]  crd_cnt [VCN];
  logic [VCN-1:0] take;
  logic [VCN-1:0] give;

  // per-VC grant/return decode and credit-gated eligibility
  always_comb begin
    take = '0;
    give = '0;
    elig = '0;
    for (int unsigned v = 0; v < VCN; v++) begin
      take[v] = re && (r_vc == LA'(v));
      give[v] = crd_vld && (crd_vc == LA'(v));
      elig[v] = empty_n[v] && (crd_cnt[v] != '0);
    end
  end

  // credit counters; simultaneous grant and return cancel, returns saturate
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned v = 0; v < VCN; v++) crd_cnt[v] <= CL'(CREDITS);
    end else begin
      for (int unsigned v = 0; v < VCN; v++) begin
        if (take[v] && !give[v])
          crd_cnt[v] <= crd_cnt[v] - CL'(1);
        else if (give[v] && !take[v] && crd_cnt[v] != CL'(CREDITS))
          crd_cnt[v] <= crd_cnt[v] + CL'(1);
      end
    end
  end
`else
  logic unused_crd;

  // without credits every non-empty VC is eligible
  always_comb begin
    elig       = empty_n;
    unused_crd = ^{crd_vld, crd_vc};
  end
`endif

  xrr_arbiter #(.N(VCN)) u_arb (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  // grant whenever something is eligible and the output slot can take it
  always_comb begin
    slot_free = ~o_valid | o_ready;
    re        = gnt_any & slot_free;
    r_vc      = gnt_idx;
  end

  // output stage and round-robin pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_vc    <= '0;
      rr_ptr  <= '0;
    end else if (re) begin
      o_valid <= 1'b1;
      o_data  <= q[int'(r_vc)*D +: D];
      o_vc    <= r_vc;
      rr_ptr  <= (r_vc == LA'(VCN - 1)) ? '0 : r_vc + LA'(1);
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
